seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_decode.sv | 32 +++
 rtl/seg7_scan.sv | 93 +++++++++
 tb/tb_seg7_scan.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the eight-digit seven-segment scanner: geometry and
// active-low segment codes in {g,f,e,d,c,b,a} order.
package seg7_pkg;

   localparam int unsigned SEG_W  = 7;
   localparam int unsigned DIGITS = 8;
   localparam int unsigned NIB_W  = 4;

   localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
   localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
   localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
   localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
   localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
   localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
   localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
   localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
   localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
   localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
   localparam logic [SEG_W-1:0] SEG_A     = 7'h08;
   localparam logic [SEG_W-1:0] SEG_B     = 7'h03;
   localparam logic [SEG_W-1:0] SEG_C     = 7'h46;
   localparam logic [SEG_W-1:0] SEG_D     = 7'h21;
   localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to active-low segment decoder; E shows a dash and
// F is fully dark so callers can embed separators and gaps in the data.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [NIB_W-1:0] nibble,
   output logic [SEG_W-1:0] seg_c
);

   always_comb begin
      seg_c = SEG_BLANK;
      case (nibble)
         4'h0: seg_c = SEG_0;
         4'h1: seg_c = SEG_1;
         4'h2: seg_c = SEG_2;
         4'h3: seg_c = SEG_3;
         4'h4: seg_c = SEG_4;
         4'h5: seg_c = SEG_5;
         4'h6: seg_c = SEG_6;
         4'h7: seg_c = SEG_7;
         4'h8: seg_c = SEG_8;
         4'h9: seg_c = SEG_9;
         4'hA: seg_c = SEG_A;
         4'hB: seg_c = SEG_B;
         4'hC: seg_c = SEG_C;
         4'hD: seg_c = SEG_D;
         4'hE: seg_c = SEG_DASH;
         default: seg_c = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment scanner with per-slot anti-ghost
// blanking and whole-frame snapshotting. Define SEG7_LZB_EN to blank leading zeros.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 50000000,
   parameter int unsigned SCAN_HZ   = 1000,
   parameter int unsigned BLANK_CYC = 500
) (
   input  logic                    clk_50mhz,
   input  logic                    rst,
   input  logic [DIGITS*NIB_W-1:0] din,
   input  logic [DIGITS-1:0]       dp_en,
   output logic [SEG_W-1:0]        seg,
   output logic                    dp,
   output logic [DIGITS-1:0]       an,
   output logic                    frame_start
);

   localparam int unsigned DIV   = CLK_HZ / SCAN_HZ;
   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned IDX_W = 3;

   logic [CNT_W-1:0]        cnt;
   logic [IDX_W-1:0]        idx;
   logic [DIGITS*NIB_W-1:0] frame;
   logic [DIGITS-1:0]       frame_dp;
   logic                    cnt_last;
   logic                    dark;
   logic [NIB_W-1:0]        nibble;
   logic [SEG_W-1:0]        seg_raw;
   logic [SEG_W-1:0]        seg_dig;

   assign cnt_last = (cnt == CNT_W'(DIV - 1));
   assign dark     = (cnt < CNT_W'(BLANK_CYC));
   assign nibble   = frame[{idx, 2'b00} +: NIB_W];

   // Frame boundary: this cycle's inputs become the snapshot for the next frame.
   assign frame_start = ~rst & (cnt == '0) & (idx == '0);

   seg7_decode u_decode (
      .nibble (nibble),
      .seg_c  (seg_raw)
   );

`ifdef SEG7_LZB_EN
   logic [DIGITS-1:0] lead_zero;

   // lead_zero[k]: nibble k and every nibble above it are zero.
   always_comb begin
      lead_zero = '0;
      for (int k = 0; k < DIGITS; k++) begin
         lead_zero[k] = ((frame >> (NIB_W * k)) == '0);
      end
   end

   assign seg_dig = ((idx != '0) && lead_zero[idx]) ? SEG_BLANK : seg_raw;
`else
   assign seg_dig = seg_raw;
`endif

   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         cnt      <= '0;
         idx      <= '0;
         frame    <= '1;
         frame_dp <= '0;
         an       <= '1;
         seg      <= SEG_BLANK;
         dp       <= 1'b1;
      end else begin
         cnt <= cnt_last ? '0 : cnt + CNT_W'(1);
         if (cnt_last) begin
            idx <= idx + IDX_W'(1);
         end
         if (frame_start) begin
            frame    <= din;
            frame_dp <= dp_en;
         end
         // Outputs follow the slot state of this cycle, visible one clock later.
         if (dark) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
         end else begin
            an  <= ~(DIGITS'(1) << idx);
            seg <= seg_dig;
            dp  <= ~frame_dp[idx];
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: a cycle-count reference model pushes the
// expected outputs per clock, and a negedge monitor pops and compares them.
module tb_seg7_scan;

   localparam int DIV_M   = 10;
   localparam int BLANK_M = 2;
   localparam int FRAME_M = DIV_M * 8;

   logic        clk_50mhz = 1'b0;
   logic        rst       = 1'b1;
   logic [31:0] din       = 32'h0;
   logic [7:0]  dp_en     = 8'h0;
   logic [6:0]  seg;
   logic        dp;
   logic [7:0]  an;
   logic        frame_start;

   seg7_scan #(
      .CLK_HZ    (1000),
      .SCAN_HZ   (100),
      .BLANK_CYC (2)
   ) dut (
      .clk_50mhz   (clk_50mhz),
      .rst         (rst),
      .din         (din),
      .dp_en       (dp_en),
      .seg         (seg),
      .dp          (dp),
      .an          (an),
      .frame_start (frame_start)
   );

   always #5 clk_50mhz = ~clk_50mhz;

   typedef struct {
      bit         chk;
      logic [7:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fs;
   } exp_t;

   exp_t q[$];

   int vectors    = 0;
   int miscompares = 0;

   logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h3F, 7'h7F};

   // Reference model state: cycles since reset release plus the displayed frame.
   int          c        = 0;
   bit          prev_rst = 1'b0;
   bit          first    = 1'b1;
   logic [31:0] mframe   = 32'hFFFF_FFFF;
   logic [7:0]  mdp      = 8'h00;

   function automatic logic [6:0] model_seg(input logic [31:0] f, input int slot);
      logic [31:0] sh;
      int top;
      top = 0;
      for (int j = 0; j < 8; j++) begin
         sh = f >> (4 * j);
         if (sh[3:0] != 4'h0) top = j;
      end
      sh = f >> (4 * slot);
`ifdef SEG7_LZB_EN
      if (slot > top) return 7'h7F;
`endif
      return seg_tbl[sh[3:0]];
   endfunction

   task automatic step(input logic r, input logic [31:0] d, input logic [7:0] e);
      exp_t x;
      int pc;
      int slot;
      @(posedge clk_50mhz);
      #1;
      rst   = r;
      din   = d;
      dp_en = e;
      x.chk = !first;
      x.fs  = !r && (c % FRAME_M == 0);
      if (prev_rst) begin
         x.an = 8'hFF; x.seg = 7'h7F; x.dp = 1'b1;
      end else begin
         pc   = c - 1;
         slot = (pc / DIV_M) % 8;
         if (pc % DIV_M < BLANK_M) begin
            x.an = 8'hFF; x.seg = 7'h7F; x.dp = 1'b1;
         end else begin
            x.an  = ~(8'd1 << slot);
            x.seg = model_seg(mframe, slot);
            x.dp  = ~mdp[slot];
         end
      end
      q.push_back(x);
      if (r) begin
         c      = 0;
         mframe = 32'hFFFF_FFFF;
         mdp    = 8'h00;
      end else begin
         if (c % FRAME_M == 0) begin
            mframe = d;
            mdp    = e;
         end
         c++;
      end
      prev_rst = r;
      first    = 1'b0;
   endtask

   task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, expv);
      end
   endtask

   always @(negedge clk_50mhz) begin
      exp_t x;
      if (q.size() > 0) begin
         x = q.pop_front();
         if (x.chk) begin
            cmp("an", an, x.an);
            cmp("seg", {1'b0, seg}, {1'b0, x.seg});
            cmp("dp", {7'b0, dp}, {7'b0, x.dp});
            cmp("frame_start", {7'b0, frame_start}, {7'b0, x.fs});
         end
      end
   end

   initial begin
      logic [31:0] rd;
      logic [7:0]  re;
      logic        rr;

      // Reset held three clocks, then scan 12345678 and tear-test with 0 mid-frame.
      repeat (3) step(1'b1, 32'h1234_5678, 8'h00);
      for (int n = 0; n < 2 * FRAME_M; n++)
         step(1'b0, (n >= 35) ? 32'h0 : 32'h1234_5678, 8'h00);

      // Dash, blank digit and a single decimal point.
      for (int n = 0; n < 2 * FRAME_M; n++) step(1'b0, 32'h1E59_E30F, 8'h04);

      // Leading zeros.
      for (int n = 0; n < 2 * FRAME_M; n++) step(1'b0, 32'h0000_0305, 8'h21);

      // Reset at cnt=5 of slot 4, then restart from slot 0.
      while (c % FRAME_M != 45) step(1'b0, 32'h8765_4321, 8'hA5);
      step(1'b1, 32'h8765_4321, 8'hA5);
      step(1'b1, 32'h8765_4321, 8'hA5);
      for (int n = 0; n < FRAME_M + 20; n++) step(1'b0, 32'h8765_4321, 8'hA5);

      // Randomized data, dp and occasional resets.
      rd = $urandom;
      re = 8'($urandom);
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 19) == 0) begin
            rd = $urandom;
            if ($urandom_range(0, 2) == 0) rd = rd & 32'h0000_0FFF;
            re = 8'($urandom);
         end
         rr = ($urandom_range(0, 299) == 0);
         step(rr, rd, re);
      end

      repeat (2) @(negedge clk_50mhz);
      cmp("queue_drained", 8'(q.size()), 8'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
